// File: rtl/adbg_wb_cmd_decode.sv
// JTAG-side command front end for the Wishbone debug module: serial data register,
// opcode decode, one pending burst command on a valid/ready handshake, sticky error register.
module adbg_wb_cmd_decode #(
  parameter int DATAREG_LEN = 53,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  tck_i,
  input  logic                  rstn_i,
  input  logic                  module_select_i,
  input  logic                  capture_dr_i,
  input  logic                  shift_dr_i,
  input  logic                  update_dr_i,
  input  logic                  tdi_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic                  cmd_write_o,
  output logic [1:0]            cmd_size_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [CNT_WIDTH-1:0]  cmd_count_o,
  input  logic                  err_i,
  output logic                  err_o,
  output logic                  illegal_o,
  output logic                  drop_o
);

  localparam int BW        = $clog2(DATAREG_LEN + 1);
  localparam int OP_LSB    = ADDR_WIDTH + CNT_WIDTH;
  localparam int SEL_BIT   = OP_LSB - 1;
  localparam int WDATA_BIT = OP_LSB - 2;
  localparam logic [BW-1:0] FULL = BW'(DATAREG_LEN);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state_q, state_d;
  logic [DATAREG_LEN-1:0]  shift_q, shift_d;
  logic [BW-1:0]           cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic                    err_q, err_d;
  logic                    illegal_q, illegal_d;
  logic                    drop_q, drop_d;

  logic                    decode;
  logic                    err_clear;
  logic [3:0]              opcode;
  logic [3:0]              op_m1;
  logic                    count_zero;

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    count_d    = count_q;
    illegal_d  = 1'b0;
    drop_d     = 1'b0;
    err_clear  = 1'b0;

    opcode     = shift_q[OP_LSB+3:OP_LSB];
    op_m1      = opcode - 4'd1;
    count_zero = (shift_q[CNT_WIDTH-1:0] == '0);

    if (shift_dr_i && module_select_i) begin
      shift_d = {tdi_i, shift_q[DATAREG_LEN-1:1]};
    end

    if (capture_dr_i && module_select_i) begin
      cnt_d = '0;
    end else if (shift_dr_i && module_select_i && cnt_q != FULL) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Only a complete frame addressed to this module (select flag clear) decodes.
    decode = update_dr_i && module_select_i && !shift_q[DATAREG_LEN-1] && (cnt_q == FULL);

    unique case (state_q)
      IDLE: begin
        if (decode) begin
          case (opcode)
            4'h0: ;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
              if (count_zero) begin
                illegal_d = 1'b1;
              end else begin
                state_d = ISSUE;
                write_d = (opcode <= 4'h4);
                size_d  = op_m1[1:0];
                addr_d  = shift_q[OP_LSB-1:CNT_WIDTH];
                count_d = shift_q[CNT_WIDTH-1:0];
              end
            end
            4'h9: begin
              if (shift_q[SEL_BIT]) illegal_d = 1'b1;
              else                  err_clear = shift_q[WDATA_BIT];
            end
            4'hD: illegal_d = shift_q[SEL_BIT];
            default: illegal_d = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        // A new update cannot displace the pending command; it is reported and discarded.
        drop_d = decode;
        if (cmd_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_d = err_i | (err_q & ~err_clear);
  end

  always_ff @(posedge tck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
      drop_q    <= drop_d;
    end
  end

  assign cmd_valid_o = (state_q == ISSUE);
  assign cmd_write_o = write_q;
  assign cmd_size_o  = size_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_count_o = count_q;
  assign err_o       = err_q;
  assign illegal_o   = illegal_q;
  assign drop_o      = drop_q;

endmodule

// File: doc/adbg_wb_cmd_decode.md
# adbg_wb_cmd_decode

JTAG-side command front end for the Wishbone debug module. Collects the 53-bit module data register serially from TDI, decodes the opcode, address and count fields on Update-DR, and presents one validated burst command per update to the downstream Wishbone burst engine over a valid/ready handshake. It also owns the module's single internal register, the sticky error register, and executes register select/write opcodes locally.

## Interface
Parameters:
- DATAREG_LEN, 53, module data register length in bits.
- ADDR_WIDTH, 32, width of the address field.
- CNT_WIDTH, 16, width of the burst word-count field.

Ports:
- tck_i  in  1  JTAG clock; the only clock in the block.
- rstn_i  in  1  asynchronous, active-low reset.
- module_select_i  in  1  this module is selected by the top-level TAP logic.
- capture_dr_i, shift_dr_i, update_dr_i  in  1 each  TAP state strobes.
- tdi_i  in  1  serial data in.
- cmd_valid_o  out  1  command pending for the burst engine.
- cmd_ready_i  in  1  burst engine accepts the command.
- cmd_write_o  out  1  1 = write burst, 0 = read burst.
- cmd_size_o  out  2  access size: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = 64-bit.
- cmd_addr_o  out  ADDR_WIDTH  start address.
- cmd_count_o  out  CNT_WIDTH  number of words, always ≥1.
- err_i  in  1  bus-error report from the burst engine; sets the error register.
- err_o  out  1  error register contents.
- illegal_o  out  1  one-cycle pulse: reserved opcode or zero-count burst.
- drop_o  out  1  one-cycle pulse: update arrived while a command was pending.

## Operation
- Shift register, DATAREG_LEN bits:
  - When shift_dr_i && module_select_i, it shifts right and tdi_i enters bit 52.
  - Field layout: [52] module-select flag, [51:48] opcode, [47:16] address, [15:0] count.
  - For IREG opcodes, bit [47] is the register select and bit [46] is the write data.
- Bit counter, 6 bits:
  - Cleared on capture_dr_i && module_select_i.
  - Increments on each qualified shift and saturates at 53.
- Decode fires on update_dr_i && module_select_i && bit[52]==0 && counter==53. Any other update is ignored.
- FSM has two states, IDLE and ISSUE.
  - IDLE + decode of a burst opcode with count≠0 → ISSUE. This loads cmd_* and asserts cmd_valid_o.
  - ISSUE + cmd_ready_i → IDLE.
  - ISSUE + decode → drop_o pulse. The pending command is unchanged, and nothing is decoded, including IREG opcodes.
- Opcode map:
  - 0x0: NOP.
  - 0x1–0x4: write; size = opcode−1.
  - 0x5–0x8: read; size = opcode−5.
  - 0x9: IREG write.
  - 0xD: IREG select.
  - 0xA–0xC, 0xE–0xF: reserved; produce illegal_o, no other effect.
- Burst with count==0: illegal_o pulse, stay in IDLE.
- IREG select (0xD): register 0 (error) is the only register, so there is no state change. If select bit ≠0, pulse illegal_o.
- IREG write (0x9) with select bit 0:
  - bit[46]=1 clears the error register.
  - bit[46]=0 has no effect.
  - select bit ≠0 pulses illegal_o.
- Error register:
  - Set when err_i is high.
  - Cleared by an IREG write clear.
  - If err_i and a clear occur in the same cycle, set wins.
- cmd_* fields are registered and stay stable for the whole time cmd_valid_o is high.

## Timing
- Reset values: cmd_valid_o=0, cmd_write_o=0, cmd_size_o=0, cmd_addr_o=0, cmd_count_o=0, err_o=0, illegal_o=0, drop_o=0. Shift register, counter and FSM also clear (FSM to IDLE).
- Decode at edge N (update_dr_i sampled high) gives:
  - cmd_valid_o high from cycle N+1;
  - illegal_o or drop_o high for cycle N+1 only;
  - error clear visible on err_o at N+1.
- Handshake: the command transfers on a rising edge where cmd_valid_o && cmd_ready_i. cmd_valid_o is low the next cycle.
  - cmd_ready_i high while cmd_valid_o is low has no effect.
- err_i sampled at edge N → err_o=1 at N+1.
- Shifting is allowed in the ISSUE state; the shift register is independent of the pending command.
- rstn_i asserted mid-ISSUE: all outputs drop asynchronously. The pending command is lost and not replayed.

## Test plan
- Shift 53 bits with opcode 0x3, addr 0x1000_0000, count 4. Hold cmd_ready_i low 3 cycles, then high → cmd_valid_o rises the cycle after update with write=1, size=2, addr 0x1000_0000, count 4, all stable for 3 cycles; valid drops one cycle after ready.
- Opcode 0x7 with count 0 → single illegal_o pulse, cmd_valid_o stays 0. Opcode 0xB → single illegal_o pulse. Opcode 0x8, count 1 → write=0, size=3.
- Pulse err_i → err_o=1. Then IREG write (0x9) with [47]=0, [46]=1 → err_o=0 one cycle after update. Repeat with err_i high on the update cycle → err_o stays 1.
- Short shift of 20 bits followed by update → no output activity. 53 bits shifted with module_select_i low → shift register unchanged.
- Read command pending (ready low), then a second update with opcode 0x1 → drop_o pulse; pending fields unchanged.
- rstn_i low for 1 cycle while cmd_valid_o=1 and err_o=1 → both 0 immediately, FSM IDLE; next valid 53-bit shift decodes normally.
